mio_timer_bus: RTL and testbench
================================

Name: mio_timer_bus

Overview:
- Parametrised memory-mapped I/O bus decoder sitting between the CPU data port and the peripherals: VRAM, keyboard I/O, seven-segment, ROM, RAM.
- Routes address, write data, read data and strobes to each peripheral.
- Hosts an internal register block: cursor row/column, keyboard F0 latch, a sticky status/flag register, and N_TIMERS independent down-counting timers with reload, auto-reload and interrupt.

Parameters:
- N_TIMERS, 2, number of timer channels (1..8).
- TIMER_W, 32, timer counter width in bits (8..32).
- RAM_AW, 6, RAM word-address width; ram_a = mem_a[RAM_AW+1:2].
- REG_BASE, 32'h0000_1000, base byte address of the internal register block.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_a  in  32  CPU byte address.
- d_t_mem  in  32  CPU write data.
- d_f_mem  out  32  CPU read data, combinational.
- wmem  in  1  CPU write strobe.
- rmem  in  1  CPU read strobe.
- vga_a  out  32  = mem_a.
- d_t_vga  out  32  = d_t_mem.
- d_f_vga  in  7  VRAM char read data.
- wvram  out  1  VRAM write, = wmem & vram space.
- rvram  out  1  VRAM read, = rmem & vram space.
- io_rdn  out  1  keyboard read, active low.
- ready  in  1  keyboard data valid.
- key_data  in  8  keyboard scan code.
- d_f_seg  in  32  segment readback.
- d_t_seg  out  32  = d_t_mem.
- wseg  out  1  segment write.
- rom_a  out  32  = mem_a.
- d_f_rom  in  32  ROM data.
- ram_a  out  RAM_AW  RAM word address.
- d_f_ram  in  32  RAM data.
- wram  out  1  RAM write.
- d_t_ram  out  32  = d_t_mem.
- irq  out  1  timer interrupt, level.

Behaviour:
- Address decode (combinational, priority in this order):
  - vram: 0xC000_0000–0xDFFF_FFFF
  - io: 0xA000_0000–0xBFFF_FFFF
  - seg: 0x0000_7F10–0x0000_7F1F
  - rom: 0x0000_0000–0x0000_07FF
  - ram: 0x0000_0800–0x0000_0FFF
  - reg: REG_BASE to REG_BASE+0x10+16*N_TIMERS-1
  - Unmapped reads return 0; unmapped writes are ignored.
- Read mux for external spaces: vram returns {25'h0, d_f_vga}; io returns {23'h0, ready, key_data}.
- Internal register map, word-aligned, offsets from REG_BASE; mem_a[1:0] ignored:
  - 0x00 CURSOR_ROW (RW)
  - 0x04 CURSOR_COL (RW)
  - 0x08 KBD_F0 (RW)
  - 0x0C STATUS (bits[N_TIMERS-1:0] = timer flags, W1C; upper bits read 0)
  - Timer i at 0x10+16*i: +0 LOAD (RW), +4 COUNT (RO), +8 CTRL (bit0 EN, bit1 AUTO, bit2 IE; other bits read 0), +C reserved (reads 0).
- Register writes take effect on the rising edge when wmem is high and the address hits.
- Reads are combinational and return the current register value; a write and a read in the same cycle return the old value.
- Timer values are zero-extended to 32 bits on read; writes truncate to TIMER_W.
- Reset values: all registers 0, COUNT 0, all flags 0, irq 0.
  - Reset is synchronous and dominates any same-cycle write or timer event.
  - Reset mid-count stops every timer and clears pending flags.
- Timer per cycle, evaluated in priority order:
  1. A write to LOAD sets LOAD and COUNT to the written value this edge; no decrement or expiry is evaluated this cycle.
  2. A write to CTRL with EN=1 while COUNT==0 loads COUNT from LOAD.
  3. Otherwise, if EN=1 and COUNT!=0: COUNT decrements by 1.
  4. If EN=1 and COUNT==0 (expiry): flag[i] is set. With AUTO=1, COUNT reloads from LOAD; with AUTO=0, EN clears and COUNT stays 0.
- Timer period is LOAD+1 cycles.
- LOAD=0 with AUTO=1: expiry every cycle; flag stays set.
- Flag set and W1C in the same cycle: set wins, flag stays 1.
- irq = OR over i of (flag[i] & IE[i]), registered; asserts 1 cycle after the flag sets.

Decomposition:
- Shared package mio_pkg:
  - space base/limit constants
  - register offsets (OFF_CURSOR_ROW, OFF_STATUS, TMR_STRIDE=16, ...)
  - CTRL bit indices (CTRL_EN=0, CTRL_AUTO=1, CTRL_IE=2)
- Sub-module mio_timer: one channel.
  - Ports: clk, rst, load_we, load_d, ctrl_we, ctrl_d, count, ctrl, expire.
  - Instantiated N_TIMERS times via generate.
  - Status flags, irq and the decode/mux stay in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles while wmem writes CURSOR_ROW=5 → all reads 0, irq=0; after rst falls, write 0x1000=5 → read 0x1000 returns 5; read 0x1004 returns 0.
- One-shot: LOAD0=3, CTRL0=0b101 → COUNT reads 3,2,1,0; flag0 sets on the 5th edge; irq rises 1 cycle later; EN reads 0; COUNT holds 0.
- Auto-reload: LOAD1=2, CTRL1=0b011 → STATUS bit1 sets every 3 cycles; write STATUS=0x2 in a non-expiry cycle → clears; write in an expiry cycle → stays 1.
- Load during count: timer0 running at COUNT=7, write LOAD0=20 → next read COUNT=20, no expiry that cycle.
- Decode: mem_a=0xC000_0004, wmem=1 → wvram=1, wseg=0, wram=0; mem_a=0x0000_0804, wmem=1 → wram=1, ram_a=1; mem_a=0xA000_0000, rmem=1, ready=1, key_data=0x1C → io_rdn=0, d_f_mem=0x11C.
- Unmapped/reserved: read 0x0000_2000 → 0; read timer reserved +0xC → 0; write 0x0000_2000 → no register changes.

Source files
------------

// File: rtl/mio_pkg.sv
// mio_pkg: address map, register offsets and timer control bits shared by the MIO bus.
package mio_pkg;
    localparam logic [31:0] VRAM_BASE = 32'hC000_0000;
    localparam logic [31:0] VRAM_LIMIT = 32'hDFFF_FFFF;
    localparam logic [31:0] IO_BASE = 32'hA000_0000;
    localparam logic [31:0] IO_LIMIT = 32'hBFFF_FFFF;
    localparam logic [31:0] SEG_BASE = 32'h0000_7F10;
    localparam logic [31:0] SEG_LIMIT = 32'h0000_7F1F;
    localparam logic [31:0] ROM_LIMIT = 32'h0000_07FF;
    localparam logic [31:0] RAM_BASE = 32'h0000_0800;
    localparam logic [31:0] RAM_LIMIT = 32'h0000_0FFF;
    localparam logic [31:0] OFF_CURSOR_ROW = 32'h00;
    localparam logic [31:0] OFF_CURSOR_COL = 32'h04;
    localparam logic [31:0] OFF_KBD_F0 = 32'h08;
    localparam logic [31:0] OFF_STATUS = 32'h0C;
    localparam logic [31:0] OFF_TMR0 = 32'h10;
    localparam logic [31:0] TMR_STRIDE = 32'd16;
    localparam logic [31:0] TMR_LOAD = 32'h0;
    localparam logic [31:0] TMR_COUNT = 32'h4;
    localparam logic [31:0] TMR_CTRL = 32'h8;
    localparam int CTRL_EN = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IE = 2;
endpackage

// File: rtl/mio_timer.sv
// mio_timer: one down-counting timer channel with reload, auto-reload and expiry pulse.
module mio_timer
    import mio_pkg::*;
#(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_we,
    input  logic [TIMER_W-1:0] load_d,
    input  logic               ctrl_we,
    input  logic [2:0]         ctrl_d,
    output logic [TIMER_W-1:0] count,
    output logic [TIMER_W-1:0] load,
    output logic [2:0]         ctrl,
    output logic               expire
);
    logic [TIMER_W-1:0] count_q, load_q;
    logic [2:0] ctrl_q;
    // Any register write to this channel suppresses decrement and expiry for that cycle.
    assign expire = ctrl_q[CTRL_EN] && count_q == '0 && !load_we && !ctrl_we;
    assign count = count_q;
    assign load = load_q;
    assign ctrl = ctrl_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            load_q <= '0;
            ctrl_q <= '0;
        end else if (load_we) begin
            load_q <= load_d;
            count_q <= load_d;
        end else if (ctrl_we) begin
            ctrl_q <= ctrl_d;
            if (ctrl_d[CTRL_EN] && count_q == '0) count_q <= load_q;
        end else if (expire) begin
            if (ctrl_q[CTRL_AUTO]) count_q <= load_q;
            else ctrl_q[CTRL_EN] <= 1'b0;
        end else if (ctrl_q[CTRL_EN]) begin
            count_q <= count_q - TIMER_W'(1);
        end
    end
endmodule

// File: rtl/mio_timer_bus.sv
// mio_timer_bus: CPU memory-mapped I/O decoder with cursor/keyboard/status registers and timers.
module mio_timer_bus
    import mio_pkg::*;
#(
    parameter int          N_TIMERS = 2,
    parameter int          TIMER_W = 32,
    parameter int          RAM_AW = 6,
    parameter logic [31:0] REG_BASE = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_a,
    input  logic [31:0]       d_t_mem,
    output logic [31:0]       d_f_mem,
    input  logic              wmem,
    input  logic              rmem,
    output logic [31:0]       vga_a,
    output logic [31:0]       d_t_vga,
    input  logic [6:0]        d_f_vga,
    output logic              wvram,
    output logic              rvram,
    output logic              io_rdn,
    input  logic              ready,
    input  logic [7:0]        key_data,
    input  logic [31:0]       d_f_seg,
    output logic [31:0]       d_t_seg,
    output logic              wseg,
    output logic [31:0]       rom_a,
    input  logic [31:0]       d_f_rom,
    output logic [RAM_AW-1:0] ram_a,
    input  logic [31:0]       d_f_ram,
    output logic              wram,
    output logic [31:0]       d_t_ram,
    output logic              irq
);
    localparam logic [31:0] REG_LIMIT = REG_BASE + OFF_TMR0 + 32'(TMR_STRIDE * N_TIMERS) - 32'd1;
    logic hit_vram, hit_io, hit_seg, hit_rom, hit_ram, hit_reg, is_tmr, w_reg, irq_q;
    logic [29:0] offw, toffw;
    logic [27:0] tidx;
    logic [1:0] tsub;
    logic [31:0] row_q, col_q, f0_q, reg_rd;
    logic [N_TIMERS-1:0] flag_q, flag_d, w1c, load_we, ctrl_we, expire, ie;
    logic [TIMER_W-1:0] count [N_TIMERS];
    logic [TIMER_W-1:0] load [N_TIMERS];
    logic [2:0] ctrl [N_TIMERS];
    assign hit_vram = mem_a >= VRAM_BASE && mem_a <= VRAM_LIMIT;
    assign hit_io = mem_a >= IO_BASE && mem_a <= IO_LIMIT;
    assign hit_seg = mem_a >= SEG_BASE && mem_a <= SEG_LIMIT;
    assign hit_rom = mem_a <= ROM_LIMIT;
    assign hit_ram = mem_a >= RAM_BASE && mem_a <= RAM_LIMIT;
    assign hit_reg = !(hit_vram || hit_io || hit_seg || hit_rom || hit_ram) &&
                     mem_a >= REG_BASE && mem_a <= REG_LIMIT;
    // Word offsets into the register block; each timer occupies four words.
    assign offw = mem_a[31:2] - REG_BASE[31:2];
    assign toffw = offw - OFF_TMR0[31:2];
    assign tidx = toffw[29:2];
    assign tsub = toffw[1:0];
    assign is_tmr = hit_reg && offw >= OFF_TMR0[31:2];
    assign w_reg = wmem && hit_reg;
    assign vga_a = mem_a;
    assign d_t_vga = d_t_mem;
    assign wvram = wmem && hit_vram;
    assign rvram = rmem && hit_vram;
    assign io_rdn = !(rmem && hit_io);
    assign d_t_seg = d_t_mem;
    assign wseg = wmem && hit_seg;
    assign rom_a = mem_a;
    assign ram_a = mem_a[RAM_AW+1:2];
    assign wram = wmem && hit_ram;
    assign d_t_ram = d_t_mem;
    assign irq = irq_q;
    assign d_f_mem = hit_vram ? {25'h0, d_f_vga} :
                     hit_io   ? {23'h0, ready, key_data} :
                     hit_seg  ? d_f_seg :
                     hit_rom  ? d_f_rom :
                     hit_ram  ? d_f_ram :
                     hit_reg  ? reg_rd : '0;
    always_comb begin
        reg_rd = offw == OFF_CURSOR_ROW[31:2] ? row_q :
                 offw == OFF_CURSOR_COL[31:2] ? col_q :
                 offw == OFF_KBD_F0[31:2]     ? f0_q :
                 offw == OFF_STATUS[31:2]     ? 32'(flag_q) : '0;
        for (int i = 0; i < N_TIMERS; i++)
            if (is_tmr && tidx == 28'(i))
                reg_rd = tsub == TMR_LOAD[3:2]  ? 32'(load[i]) :
                         tsub == TMR_COUNT[3:2] ? 32'(count[i]) :
                         tsub == TMR_CTRL[3:2]  ? 32'(ctrl[i]) : '0;
    end
    for (genvar g = 0; g < N_TIMERS; g++) begin : g_tmr
        assign ie[g] = ctrl[g][CTRL_IE];
        assign load_we[g] = wmem && is_tmr && tidx == 28'(g) && tsub == TMR_LOAD[3:2];
        assign ctrl_we[g] = wmem && is_tmr && tidx == 28'(g) && tsub == TMR_CTRL[3:2];
        mio_timer #(.TIMER_W(TIMER_W)) u_tmr (
            .clk    (clk),
            .rst    (rst),
            .load_we(load_we[g]),
            .load_d (d_t_mem[TIMER_W-1:0]),
            .ctrl_we(ctrl_we[g]),
            .ctrl_d (d_t_mem[2:0]),
            .count  (count[g]),
            .load   (load[g]),
            .ctrl   (ctrl[g]),
            .expire (expire[g])
        );
    end
    // A flag set by expiry wins over a same-cycle write-one-to-clear.
    assign w1c = (w_reg && offw == OFF_STATUS[31:2]) ? d_t_mem[N_TIMERS-1:0] : '0;
    assign flag_d = (flag_q & ~w1c) | expire;
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
            f0_q <= '0;
            flag_q <= '0;
            irq_q <= 1'b0;
        end else begin
            if (w_reg && offw == OFF_CURSOR_ROW[31:2]) row_q <= d_t_mem;
            if (w_reg && offw == OFF_CURSOR_COL[31:2]) col_q <= d_t_mem;
            if (w_reg && offw == OFF_KBD_F0[31:2]) f0_q <= d_t_mem;
            flag_q <= flag_d;
            irq_q <= |(flag_q & ie);
        end
    end
endmodule

// File: tb/tb_mio_timer_bus.sv
// tb_mio_timer_bus: directed and randomized checks of the MIO bus against a behavioural model.
module tb_mio_timer_bus;
    localparam int NT = 2;
    localparam int TW = 32;
    localparam logic [31:0] RB = 32'h0000_1000;
    logic clk = 0, rst = 1;
    logic [31:0] mem_a = 0, d_t_mem = 0;
    logic wmem = 0, rmem = 0;
    logic [6:0] d_f_vga = 0;
    logic ready = 0;
    logic [7:0] key_data = 0;
    logic [31:0] d_f_seg = 0, d_f_rom = 0, d_f_ram = 0;
    logic [31:0] d_f_mem, vga_a, d_t_vga, d_t_seg, rom_a, d_t_ram;
    logic wvram, rvram, io_rdn, wseg, wram, irq;
    logic [5:0] ram_a;
    logic [31:0] m_row, m_col, m_f0;
    logic [TW-1:0] m_load [NT];
    logic [TW-1:0] m_cnt [NT];
    logic m_en [NT];
    logic m_auto [NT];
    logic m_ie [NT];
    logic m_flag [NT];
    logic m_irq;
    bit started = 0;
    int n_cmp = 0, n_bad = 0;

    mio_timer_bus #(.N_TIMERS(NT), .TIMER_W(TW), .RAM_AW(6), .REG_BASE(RB)) dut (
        .clk(clk), .rst(rst), .mem_a(mem_a), .d_t_mem(d_t_mem), .d_f_mem(d_f_mem),
        .wmem(wmem), .rmem(rmem), .vga_a(vga_a), .d_t_vga(d_t_vga), .d_f_vga(d_f_vga),
        .wvram(wvram), .rvram(rvram), .io_rdn(io_rdn), .ready(ready), .key_data(key_data),
        .d_f_seg(d_f_seg), .d_t_seg(d_t_seg), .wseg(wseg), .rom_a(rom_a), .d_f_rom(d_f_rom),
        .ram_a(ram_a), .d_f_ram(d_f_ram), .wram(wram), .d_t_ram(d_t_ram), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int region(input logic [31:0] a);
        if (a >= 32'hC000_0000 && a <= 32'hDFFF_FFFF) return 1;
        if (a >= 32'hA000_0000 && a <= 32'hBFFF_FFFF) return 2;
        if (a >= 32'h7F10 && a <= 32'h7F1F) return 3;
        if (a <= 32'h7FF) return 4;
        if (a <= 32'hFFF) return 5;
        if (a >= RB && a < RB + 32'h10 + 32'(16 * NT)) return 6;
        return 0;
    endfunction

    function automatic logic [31:0] reg_val(input logic [31:0] a);
        int unsigned o, t, r;
        logic [31:0] v;
        o = (a - RB) & 32'hFFFF_FFFC;
        if (o == 0) return m_row;
        if (o == 4) return m_col;
        if (o == 8) return m_f0;
        if (o == 12) begin
            v = 0;
            for (int i = 0; i < NT; i++) v[i] = m_flag[i];
            return v;
        end
        t = (o - 16) / 16;
        r = (o - 16) % 16;
        if (r == 0) return 32'(m_load[t]);
        if (r == 4) return 32'(m_cnt[t]);
        if (r == 8) return {29'h0, m_ie[t], m_auto[t], m_en[t]};
        return 0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        case (region(a))
            1: return {25'h0, d_f_vga};
            2: return {23'h0, ready, key_data};
            3: return d_f_seg;
            4: return d_f_rom;
            5: return d_f_ram;
            6: return reg_val(a);
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        int rg;
        int unsigned o;
        logic [NT-1:0] ex;
        logic irq_n, wl, wc;
        if (rst) begin
            m_row = 0; m_col = 0; m_f0 = 0; m_irq = 0;
            for (int i = 0; i < NT; i++) begin
                m_load[i] = 0; m_cnt[i] = 0; m_en[i] = 0; m_auto[i] = 0; m_ie[i] = 0; m_flag[i] = 0;
            end
        end else begin
            rg = region(mem_a);
            o = (mem_a - RB) & 32'hFFFF_FFFC;
            irq_n = 0;
            for (int i = 0; i < NT; i++) irq_n = irq_n | (m_flag[i] & m_ie[i]);
            ex = 0;
            for (int i = 0; i < NT; i++) begin
                wl = wmem && rg == 6 && o == 32'(16 + 16 * i);
                wc = wmem && rg == 6 && o == 32'(24 + 16 * i);
                if (wl) begin
                    m_load[i] = d_t_mem[TW-1:0];
                    m_cnt[i] = d_t_mem[TW-1:0];
                end else if (wc) begin
                    m_en[i] = d_t_mem[0]; m_auto[i] = d_t_mem[1]; m_ie[i] = d_t_mem[2];
                    if (d_t_mem[0] && m_cnt[i] == 0) m_cnt[i] = m_load[i];
                end else if (m_en[i] && m_cnt[i] == 0) begin
                    ex[i] = 1;
                    if (m_auto[i]) m_cnt[i] = m_load[i];
                    else m_en[i] = 0;
                end else if (m_en[i]) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
            if (wmem && rg == 6) begin
                if (o == 0) m_row = d_t_mem;
                if (o == 4) m_col = d_t_mem;
                if (o == 8) m_f0 = d_t_mem;
                if (o == 12) for (int i = 0; i < NT; i++) if (d_t_mem[i]) m_flag[i] = 0;
            end
            for (int i = 0; i < NT; i++) if (ex[i]) m_flag[i] = 1;
            m_irq = irq_n;
        end
    endtask

    task automatic step(input logic r_, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic rd);
        @(posedge clk);
        model_step();
        started = 1;
        #1;
        rst = r_; mem_a = a; d_t_mem = d; wmem = w; rmem = rd;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(0, a, d, 1, 0);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        step(0, a, 0, 0, 1);
        chk(nm, d_f_mem, exp);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (started) begin
            chk("rdata", d_f_mem, ref_rd(mem_a));
            chk("irq", {31'h0, irq}, {31'h0, m_irq});
            chk("strobes", {27'h0, wvram, rvram, io_rdn, wseg, wram},
                {27'h0, wmem && region(mem_a) == 1, rmem && region(mem_a) == 1,
                 !(rmem && region(mem_a) == 2), wmem && region(mem_a) == 3, wmem && region(mem_a) == 5});
            chk("ram_a", {26'h0, ram_a}, {26'h0, mem_a[7:2]});
            chk("pass_a", vga_a ^ rom_a, 32'h0);
            chk("vga_a", vga_a, mem_a);
            chk("d_t", d_t_vga & d_t_seg & d_t_ram, d_t_mem);
        end
    end

    initial begin
        step(1, RB, 5, 1, 0);
        step(1, RB, 5, 1, 0);
        rd_chk("rst_row", RB, 0);
        chk("rst_irq", {31'h0, irq}, 0);
        wr(RB, 5);
        rd_chk("row", RB, 5);
        rd_chk("col", RB + 4, 0);
        wr(RB + 16, 3);
        wr(RB + 24, 5);
        rd_chk("os_c3", RB + 20, 3);
        rd_chk("os_c2", RB + 20, 2);
        rd_chk("os_c1", RB + 20, 1);
        rd_chk("os_c0", RB + 20, 0);
        rd_chk("os_flag", RB + 12, 1);
        chk("os_irq0", {31'h0, irq}, 0);
        rd_chk("os_ctrl", RB + 24, 4);
        chk("os_irq1", {31'h0, irq}, 1);
        rd_chk("os_hold", RB + 20, 0);
        wr(RB + 24, 0);
        wr(RB + 12, 1);
        rd_chk("os_clr", RB + 12, 0);
        wr(RB + 32, 2);
        wr(RB + 40, 3);
        rd_chk("ar_c2", RB + 36, 2);
        rd_chk("ar_c1", RB + 36, 1);
        rd_chk("ar_c0", RB + 36, 0);
        rd_chk("ar_set", RB + 12, 2);
        wr(RB + 12, 2);
        rd_chk("ar_clr", RB + 12, 0);
        rd_chk("ar_set2", RB + 12, 2);
        rd_chk("ar_c1b", RB + 36, 1);
        wr(RB + 12, 2);
        rd_chk("ar_setwin", RB + 12, 2);
        wr(RB + 40, 0);
        wr(RB + 12, 2);
        rd_chk("ar_off", RB + 12, 0);
        wr(RB + 16, 10);
        wr(RB + 24, 1);
        rd_chk("ld_c10", RB + 20, 10);
        rd_chk("ld_c9", RB + 20, 9);
        rd_chk("ld_c8", RB + 20, 8);
        wr(RB + 16, 20);
        rd_chk("ld_c20", RB + 20, 20);
        rd_chk("ld_noexp", RB + 12, 0);
        wr(RB + 24, 0);
        step(0, 32'hC000_0004, 32'hAB, 1, 0);
        chk("dec_vram", {29'h0, wvram, wseg, wram}, 32'h4);
        step(0, 32'h0000_0804, 32'hAB, 1, 0);
        chk("dec_wram", {31'h0, wram}, 1);
        chk("dec_ram_a", {26'h0, ram_a}, 1);
        ready = 1;
        key_data = 8'h1C;
        step(0, 32'hA000_0000, 0, 0, 1);
        chk("dec_io_rdn", {31'h0, io_rdn}, 0);
        chk("dec_io_data", d_f_mem, 32'h11C);
        rd_chk("unm_rd", 32'h2000, 0);
        rd_chk("rsv_rd", RB + 28, 0);
        wr(32'h2000, 32'hFFFF_FFFF);
        rd_chk("unm_row", RB, 5);
        rd_chk("unm_col", RB + 4, 0);
        for (int k = 0; k < 3000; k++) begin
            int kind;
            logic [31:0] a, d;
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3, 4: a = RB + $urandom_range(0, 16 + 16 * NT - 1);
                5: a = 32'hC000_0000 | ($urandom & 32'h1FFF_FFFF);
                6: a = 32'hA000_0000 | ($urandom & 32'h1FFF_FFFF);
                7: a = 32'h7F10 + $urandom_range(0, 15);
                8: a = $urandom_range(0, 32'hFFF);
                default: a = (k % 2 == 1) ? $urandom : RB + 32'(16 + 16 * NT) + $urandom_range(0, 63);
            endcase
            d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 7);
            d_f_vga = 7'($urandom);
            ready = 1'($urandom);
            key_data = 8'($urandom);
            d_f_seg = $urandom;
            d_f_rom = $urandom;
            d_f_ram = $urandom;
            step($urandom_range(0, 199) == 0, a, d, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
